// File: rtl/wb_queue_pkg.sv
// Shared constants and types for the register-file write-back queue.
// RF_* mirror the register-file header; WBQ_* are the queue's own sizing.
package wb_queue_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  localparam logic                 RF_WRITE_ENABLED = 1'b1;
  localparam logic [RF_ADDR_W-1:0] RF_ADDR_ZERO     = 5'd0;

  localparam int WBQ_DEPTH       = 4;
  localparam int WBQ_COUNT_WIDTH = $clog2(WBQ_DEPTH + 1);

  // Register 0 is hard-wired, so writes to it never reach the register file
  function automatic logic is_real_addr(input logic [RF_ADDR_W-1:0] addr);
    return addr != RF_ADDR_ZERO;
  endfunction

endpackage

// File: rtl/wb_queue_if.sv
// Bus bundle for wb_queue: A/B write inputs, register-file write port,
// forwarding lookup and the occupancy count.
interface wb_queue_if;
  import wb_queue_pkg::*;

  // A has no ready and is always accepted. B transfers on the cycle where
  // b_valid and b_ready are both high; b_valid may be held across cycles.
  logic                       a_valid;
  logic [RF_ADDR_W-1:0]       a_addr;
  logic [RF_DATA_W-1:0]       a_data;
  logic                       b_valid;
  logic                       b_ready;
  logic [RF_ADDR_W-1:0]       b_addr;
  logic [RF_DATA_W-1:0]       b_data;
  logic                       rf_write_enable;
  logic [RF_ADDR_W-1:0]       rf_write_addr;
  logic [RF_DATA_W-1:0]       rf_write_data;
  logic [RF_ADDR_W-1:0]       q_addr;
  logic                       q_hit;
  logic [RF_DATA_W-1:0]       q_data;
  logic [WBQ_COUNT_WIDTH-1:0] count;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr,
    input  b_ready, rf_write_enable, rf_write_addr, rf_write_data,
           q_hit, q_data, count
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr,
    output b_ready, rf_write_enable, rf_write_addr, rf_write_data,
           q_hit, q_data, count
  );

endinterface

// File: rtl/wbq_entry_fifo.sv
// Circular queue of pending B writes with per-entry live bits, kill-by-address
// and a youngest-live-match search for forwarding.
module wbq_entry_fifo
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic [RF_ADDR_W-1:0] i_push_addr,
  input  logic [RF_DATA_W-1:0] i_push_data,
  input  logic                 i_pop,
  input  logic                 i_kill,
  input  logic [RF_ADDR_W-1:0] i_kill_addr,
  input  logic [RF_ADDR_W-1:0] i_q_addr,
  output logic                 o_q_hit,
  output logic [RF_DATA_W-1:0] o_q_data,
  output logic                 o_head_live,
  output logic [RF_ADDR_W-1:0] o_head_addr,
  output logic [RF_DATA_W-1:0] o_head_data,
  output logic [CW-1:0]        o_count,
  output logic                 o_full,
  output logic                 o_empty
);

  logic [RF_ADDR_W-1:0] r_addr [DEPTH];
  logic [RF_DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]     r_live;
  logic [PW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_wr_ptr;
  logic [CW-1:0]        r_count;

  logic                 w_push;
  logic                 w_pop;
  logic [PW-1:0]        w_idx;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_count = r_count;

  assign o_head_live = r_live[r_rd_ptr];
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];

  // Free slots always have live=0, so the kill can sweep every slot. The push
  // is applied after the kill so a same-cycle enqueue survives as the younger.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_live   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill && r_addr[i] == i_kill_addr) r_live[i] <= 1'b0;
      end
      if (w_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= ptr_next(r_rd_ptr);
      end
      if (w_push) begin
        r_addr[r_wr_ptr] <= i_push_addr;
        r_data[r_wr_ptr] <= i_push_data;
        r_live[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= ptr_next(r_wr_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Scan oldest to youngest so the last match wins
  always_comb begin
    o_q_hit  = 1'b0;
    o_q_data = '0;
    w_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = PW'((int'(r_rd_ptr) + k) % DEPTH);
      if (k < int'(r_count) && r_live[w_idx] && is_real_addr(i_q_addr) &&
          r_addr[w_idx] == i_q_addr) begin
        o_q_hit  = 1'b1;
        o_q_data = r_data[w_idx];
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back arbiter: priority A writes, queued B writes drained when A idles,
// registered register-file write port and combinational forwarding lookup.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  wb_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic                 r_we;
  logic [RF_ADDR_W-1:0] r_waddr;
  logic [RF_DATA_W-1:0] r_wdata;

  logic                 w_a_write;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_head_live;
  logic [RF_ADDR_W-1:0] w_head_addr;
  logic [RF_DATA_W-1:0] w_head_data;
  logic [CW-1:0]        w_count;
  logic                 w_fifo_hit;
  logic [RF_DATA_W-1:0] w_fifo_data;

  assign w_a_write = bus.a_valid && is_real_addr(bus.a_addr);
  assign bus.b_ready = !w_full;
  // Accepted B writes to register 0 are consumed here and never enqueued
  assign w_push = bus.b_valid && !w_full && is_real_addr(bus.b_addr);
  assign w_pop  = !w_a_write && !w_empty;

  wbq_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_addr (bus.b_addr),
    .i_push_data (bus.b_data),
    .i_pop       (w_pop),
    .i_kill      (w_a_write),
    .i_kill_addr (bus.a_addr),
    .i_q_addr    (bus.q_addr),
    .o_q_hit     (w_fifo_hit),
    .o_q_data    (w_fifo_data),
    .o_head_live (w_head_live),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // A dead head is still popped but leaves the write port idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_a_write) begin
      r_we    <= RF_WRITE_ENABLED;
      r_waddr <= bus.a_addr;
      r_wdata <= bus.a_data;
    end else if (w_pop && w_head_live) begin
      r_we    <= RF_WRITE_ENABLED;
      r_waddr <= w_head_addr;
      r_wdata <= w_head_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign bus.rf_write_enable = r_we;
  assign bus.rf_write_addr   = r_waddr;
  assign bus.rf_write_data   = r_wdata;
  assign bus.count           = WBQ_COUNT_WIDTH'(w_count);

  always_comb begin
    bus.q_hit  = 1'b0;
    bus.q_data = '0;
    if (w_fifo_hit) begin
      bus.q_hit  = 1'b1;
      bus.q_data = w_fifo_data;
    end else if (r_we && is_real_addr(bus.q_addr) && r_waddr == bus.q_addr) begin
      bus.q_hit  = 1'b1;
      bus.q_data = r_wdata;
    end
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of port-B queue entries; only 4 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports a_valid, input, 1, and a_addr, input, 5, and a_data, input, 32: the priority pipeline write; no ready, always accepted.
REQ-005 The block SHALL have ports b_valid, input, 1, b_ready, output, 1, b_addr, input, 5, and b_data, input, 32: the queued multi-cycle-unit write; a transfer occurs when b_valid and b_ready are both high.
REQ-006 The block SHALL have ports rf_write_enable, output, 1, rf_write_addr, output, 5, and rf_write_data, output, 32, driving the register-file write port.
REQ-007 The block SHALL have ports q_addr, input, 5, q_hit, output, 1, and q_data, output, 32, for the forwarding lookup.
REQ-008 The block SHALL have port count, output, 3, the number of occupied queue slots (0..4).

Function
REQ-009 rf_write_enable, rf_write_addr and rf_write_data SHALL be registered outputs.
REQ-010 A valid in cycle N with a_addr != 0 SHALL drive rf_write_* with {1, a_addr, a_data} in cycle N+1.
REQ-011 A writes with addr 0 SHALL be discarded: no RF write and no cancellation.
REQ-012 b_ready SHALL equal !full, where full means count == DEPTH; it SHALL NOT depend on a same-cycle drain.
REQ-013 A B transfer with b_addr 0 SHALL be accepted and discarded, and SHALL NOT be enqueued.
REQ-014 Accepted B writes SHALL enter the FIFO in order; an entry accepted in cycle N becomes head-eligible in cycle N+1.
REQ-015 Drain: in any cycle with a_valid low (or a_addr == 0) and a non-empty FIFO, the head SHALL be popped; a live head drives rf_write_* next cycle, a dead head produces no write.
REQ-016 In any cycle with no A write and no live drain, rf_write_enable SHALL be 0 next cycle.
REQ-017 Min B latency: accepted in cycle N, A idle in cycle N+1 -> RF write visible in cycle N+2.
REQ-018 Cancellation: an A write to addr X in cycle N SHALL mark dead every entry already queued with addr X.
REQ-019 A B entry accepted in the same cycle N as that A write SHALL be treated as younger and SHALL NOT be cancelled.
REQ-020 Enqueue and pop SHALL be allowed in the same cycle; count then stays unchanged.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 count SHALL include dead entries until they are popped.
REQ-023 Lookup, combinational: q_hit SHALL be 1 with q_data taken from the youngest live FIFO entry matching q_addr.
REQ-024 If no live FIFO entry matches, the lookup SHALL use the output register if rf_write_enable is high and rf_write_addr == q_addr; otherwise q_hit = 0 and q_data = 0.
REQ-025 q_addr == 0 SHALL never hit.

Reset
REQ-026 While reset is high, at the clock edge: FIFO emptied, pointers 0, count 0, all entries dead, rf_write_enable 0, rf_write_addr 0, rf_write_data 0.
REQ-027 After reset, b_ready SHALL be 1 in the first cycle.
REQ-028 Reset mid-operation SHALL drop all queued writes without emitting them; A/B inputs presented in the reset cycle SHALL be ignored.

Structure
REQ-029 Shared header constants: RF_WRITE_ENABLED and RF_ADDR_ZERO (existing rf.h), plus WBQ_DEPTH and WBQ_COUNT_WIDTH in a new wb_queue.h.
REQ-030 One sub-module, wbq_entry_fifo, SHALL hold storage, pointers, per-entry live bits, the kill-by-address input and the youngest-match search; wb_queue SHALL hold arbitration and the output register.

Verification
REQ-031 A stream: a_valid with (3, 0x11), (4, 0x22) in consecutive cycles -> rf_write_* = (3, 0x11) and then (4, 0x22), each one cycle later.
REQ-032 B fill: 5 B writes offered while a_valid is held high -> 4 accepted, b_ready low, count 4; drop a_valid -> 4 writes emitted in order, then count 0.
REQ-033 Cancel: B (7, 0xAA) queued, then A (7, 0xBB) -> only 0xBB written to reg 7; the dead entry is popped with no write and count returns to 0.
REQ-034 Same-cycle: A (5, 0x1) and B (5, 0x2) in the same cycle -> writes to reg 5 of 0x1 then 0x2; q_addr = 5 returns 0x2 while it is queued.
REQ-035 Lookup: q_addr = 0 with reg-0 traffic -> q_hit 0; q_addr = 9 with two queued writes (9, 0x3) then (9, 0x4) -> q_data 0x4.
REQ-036 Reset: assert reset with 3 entries queued -> no further RF writes, count 0, b_ready 1 the next cycle.
